// File: rtl/ofdm_tx_burst_framer_pkg.sv
// Shared constants, training sequence and FSM state type for the OFDM TX burst framer.
package ofdm_burst_pkg;

  localparam int ACTIVE_SUBCARR = 28;
  localparam int SYMBOL_NUM     = 8;
  localparam int CEST_NUM       = 4;

  // Training magnitude lives in the real byte; imaginary byte is zero.
  localparam logic signed [7:0] CEST_AMP = 8'sd64;
  localparam logic [7:0]        CEST_POS = CEST_AMP;
  localparam logic [7:0]        CEST_NEG = 8'(-CEST_AMP);

  // Bit k is subcarrier k; 1 selects +A, 0 selects -A.
  localparam logic [27:0] CEST_SEQ = 28'b1011_0100_1110_0010_1101_1001_0110;

  localparam logic [8:0] CEST_WORDS  = 9'(CEST_NUM * ACTIVE_SUBCARR);
  localparam logic [8:0] DATA_WORDS  = 9'(SYMBOL_NUM * ACTIVE_SUBCARR);
  localparam logic [8:0] BURST_WORDS = CEST_WORDS + DATA_WORDS;
  localparam logic [7:0] LAST_WR     = 8'(SYMBOL_NUM * ACTIVE_SUBCARR - 1);
  localparam logic [4:0] LAST_SC     = 5'(ACTIVE_SUBCARR - 1);

  typedef enum logic [1:0] {FILL, CEST, DATA, DONE} state_t;

  // Training word for subcarrier sc.
  function automatic logic [15:0] cest_word(input logic [4:0] sc);
    return {8'h00, (CEST_SEQ[sc] ? CEST_POS : CEST_NEG)};
  endfunction

endpackage

// File: rtl/ofdm_tx_burst_framer_bram.sv
// 256x16 single-port burst buffer with a registered (1-cycle) read port.
module ofdm_tx_data_bram (
  input  logic        clk,
  input  logic        we,
  input  logic        en,
  input  logic [7:0]  addr,
  input  logic [15:0] di,
  output logic [15:0] dout
);

  logic [15:0] r_mem [0:255];

  // Write when enabled with we; read data appears one cycle after the address.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) r_mem[addr] <= di;
      dout <= r_mem[addr];
    end
  end

endmodule

// File: rtl/ofdm_tx_burst_framer.sv
// OFDM TX burst framer: buffers one burst of data words, then streams
// channel-estimation training symbols followed by the buffered data.
// Optional feature macro: BURST_CNT_EN adds a 16-bit wrapping burst counter port.
//
// The BRAM read address runs one word ahead of the output register: when a
// data word is loaded into the output, the next address is presented in the
// same cycle, so the BRAM output register always holds the next data word.
// This removes the read-latency bubble at the training->data boundary and
// keeps throughput at one word per cycle under any backpressure pattern.
module ofdm_tx_burst_framer
  import ofdm_burst_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        wren,
  output logic        in_full,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        sym_start,
  output logic        is_cest,
  output logic        tx_done
`ifdef BURST_CNT_EN
  ,
  output logic [15:0] burst_cnt
`endif
);

  localparam logic [8:0] LAST_CEST_HS = CEST_WORDS - 9'd1;
  localparam logic [8:0] LAST_HS      = BURST_WORDS - 9'd1;

  state_t      r_state;
  logic [7:0]  r_wr_cnt;
  logic [8:0]  r_ld_cnt;
  logic [8:0]  r_hs_cnt;
  logic [7:0]  r_rd_idx;
  logic [4:0]  r_sc_cnt;
  logic [15:0] r_dout;
  logic        r_dout_valid;
  logic        r_sym_start;
  logic        r_is_cest;
  logic        r_tx_done;
  logic        r_in_full;

  logic        w_hs;
  logic        w_streaming;
  logic        w_load;
  logic        w_ld_cest;
  logic        w_take_data;
  logic        w_wr;
  logic [7:0]  w_rd_addr;
  logic [7:0]  w_bram_addr;
  logic        w_bram_en;
  logic [15:0] w_bram_rd;

  assign w_hs        = r_dout_valid && dout_ready;
  assign w_streaming = (r_state == CEST) || (r_state == DATA);
  assign w_load      = w_streaming && (r_ld_cnt < BURST_WORDS) && (!r_dout_valid || dout_ready);
  assign w_ld_cest   = r_ld_cnt < CEST_WORDS;
  assign w_take_data = w_load && !w_ld_cest;
  assign w_wr        = (r_state == FILL) && wren;
  assign w_rd_addr   = w_take_data ? (r_rd_idx + 8'd1) : r_rd_idx;
  assign w_bram_addr = (r_state == FILL) ? r_wr_cnt : w_rd_addr;
  assign w_bram_en   = w_wr || w_streaming;

  ofdm_tx_data_bram u_bram (
    .clk  (clk),
    .we   (w_wr),
    .en   (w_bram_en),
    .addr (w_bram_addr),
    .di   (din),
    .dout (w_bram_rd)
  );

  // Burst FSM: fill counter, output register load/hold, handshake counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_wr_cnt     <= '0;
      r_ld_cnt     <= '0;
      r_hs_cnt     <= '0;
      r_rd_idx     <= '0;
      r_sc_cnt     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sym_start  <= 1'b0;
      r_is_cest    <= 1'b0;
      r_tx_done    <= 1'b0;
      r_in_full    <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;

      if (w_load) begin
        r_dout_valid <= 1'b1;
        r_dout       <= w_ld_cest ? cest_word(r_sc_cnt) : w_bram_rd;
        r_sym_start  <= (r_sc_cnt == 5'd0);
        r_is_cest    <= w_ld_cest;
        r_ld_cnt     <= r_ld_cnt + 9'd1;
        r_sc_cnt     <= (r_sc_cnt == LAST_SC) ? 5'd0 : (r_sc_cnt + 5'd1);
      end else if (w_hs) begin
        r_dout_valid <= 1'b0;
      end

      if (w_take_data) r_rd_idx <= r_rd_idx + 8'd1;
      if (w_hs)        r_hs_cnt <= r_hs_cnt + 9'd1;

      case (r_state)
        FILL: begin
          if (w_wr) begin
            r_wr_cnt <= r_wr_cnt + 8'd1;
            if (r_wr_cnt == LAST_WR) begin
              r_state   <= CEST;
              r_in_full <= 1'b1;
            end
          end
        end
        CEST: begin
          if (w_hs && (r_hs_cnt == LAST_CEST_HS)) r_state <= DATA;
        end
        DATA: begin
          if (w_hs && (r_hs_cnt == LAST_HS)) begin
            r_state   <= DONE;
            r_tx_done <= 1'b1;
            r_in_full <= 1'b0;
            r_wr_cnt  <= '0;
          end
        end
        DONE: begin
          r_state  <= FILL;
          r_ld_cnt <= '0;
          r_hs_cnt <= '0;
          r_rd_idx <= '0;
          r_sc_cnt <= '0;
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign sym_start  = r_sym_start;
  assign is_cest    = r_is_cest;
  assign tx_done    = r_tx_done;
  assign in_full    = r_in_full;

`ifdef BURST_CNT_EN
  logic [15:0] r_burst_cnt;

  // Count completed bursts; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_burst_cnt <= '0;
    else if (r_state == DONE) r_burst_cnt <= r_burst_cnt + 16'd1;
  end

  assign burst_cnt = r_burst_cnt;
`endif

endmodule

// File: tb/tb_ofdm_tx_burst_framer.sv
// Directed testbench for ofdm_tx_burst_framer (optionally with BURST_CNT_EN).
module tb_ofdm_tx_burst_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        wren = 1'b0;
  logic        dout_ready = 1'b0;
  logic        in_full;
  logic [15:0] dout;
  logic        dout_valid;
  logic        sym_start;
  logic        is_cest;
  logic        tx_done;
`ifdef BURST_CNT_EN
  logic [15:0] burst_cnt;
`endif

  always #5 clk = ~clk;

  ofdm_tx_burst_framer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .wren       (wren),
    .in_full    (in_full),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sym_start  (sym_start),
    .is_cest    (is_cest),
    .tx_done    (tx_done)
`ifdef BURST_CNT_EN
    ,
    .burst_cnt  (burst_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int words;
  int done_cnt;
  int done_cyc;
  int sym_total;
  logic [27:0] seq_v = 28'b1011_0100_1110_0010_1101_1001_0110;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Training words: 0x0040 (+64) or 0x00C0 (-64); data words: base + index.
  function automatic logic [15:0] exp_word(input int k, input logic [15:0] base);
    if (k < 112) return {8'h00, (seq_v[k % 28] ? 8'h40 : 8'hC0)};
    return base + 16'(k - 112);
  endfunction

  task automatic write_burst(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wren = 1'b1;
      din  = base + 16'(i);
    end
    @(negedge clk);
    wren = 1'b0;
    din  = '0;
  endtask

  // Consume the output stream; cycle 0 is the current negedge.
  task automatic stream(input logic [15:0] base, input bit rnd, input int stop_at, input string tag);
    int k = 0;
    int stall_left = 0;
    bit stalled_done = 1'b0;
    bit held_v = 1'b0;
    logic [18:0] held = '0;
    bit r;
    int syms = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      if (tx_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (held_v) check({tag, " hold"}, 32'({dout_valid, sym_start, is_cest, dout}), 32'(held));
      if (stop_at > 0 && k == stop_at) break;
      if (k == 336 && done_cyc >= 0 && c >= done_cyc + 3) break;
      r = 1'b1;
      if (rnd) r = ($urandom_range(0, 9) >= 3);
      if (stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else if (rnd && dout_valid && k == 111 && !stalled_done) begin
        stalled_done = 1'b1;
        stall_left = 4;
        r = 1'b0;
      end
      dout_ready = r;
      if (dout_valid && r) begin
        check({tag, " word"}, 32'(dout), 32'(exp_word(k, base)));
        check({tag, " is_cest"}, 32'(is_cest), 32'(k < 112));
        check({tag, " sym_start"}, 32'(sym_start), 32'((k % 28) == 0));
        if (sym_start) syms++;
        k++;
        held_v = 1'b0;
      end else if (dout_valid) begin
        held_v = 1'b1;
        held = {dout_valid, sym_start, is_cest, dout};
      end else begin
        held_v = 1'b0;
      end
    end
    words = k;
    sym_total = syms;
  endtask

  initial begin
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst dout_valid", 32'(dout_valid), 32'd0);
    check("rst dout", 32'(dout), 32'd0);
    check("rst sym_start", 32'(sym_start), 32'd0);
    check("rst is_cest", 32'(is_cest), 32'd0);
    check("rst tx_done", 32'(tx_done), 32'd0);
    check("rst in_full", 32'(in_full), 32'd0);
`ifdef BURST_CNT_EN
    check("rst burst_cnt", 32'(burst_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // Nominal burst, ready always high
    write_burst(16'h0100, 224);
    check("s1 in_full", 32'(in_full), 32'd1);
    check("s1 early valid", 32'(dout_valid), 32'd0);
    stream(16'h0100, 1'b0, 0, "s1");
    check("s1 words", 32'(words), 32'd336);
    check("s1 tx_done count", 32'(done_cnt), 32'd1);
    check("s1 tx_done latency", 32'(done_cyc), 32'd337);
    check("s1 sym_start count", 32'(sym_total), 32'd12);
    check("s1 in_full after", 32'(in_full), 32'd0);

    // Random backpressure with a stall at the training/data boundary
    write_burst(16'h0100, 224);
    stream(16'h0100, 1'b1, 0, "s3");
    check("s3 words", 32'(words), 32'd336);
    check("s3 tx_done count", 32'(done_cnt), 32'd1);
    check("s3 sym_start count", 32'(sym_total), 32'd12);

    // Overflow: six extra writes land after the buffer is full
    dout_ready = 1'b0;
    write_burst(16'h0100, 230);
    check("s4 in_full", 32'(in_full), 32'd1);
    stream(16'h0100, 1'b0, 0, "s4");
    check("s4 words", 32'(words), 32'd336);
    check("s4 tx_done count", 32'(done_cnt), 32'd1);

    // Abort mid-burst, then a fresh burst
    dout_ready = 1'b1;
    write_burst(16'h0100, 224);
    stream(16'h0100, 1'b0, 150, "s5a");
    check("s5 words before abort", 32'(words), 32'd150);
    check("s5 no early tx_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b0;
    #1;
    check("s5 abort dout_valid", 32'(dout_valid), 32'd0);
    check("s5 abort dout", 32'(dout), 32'd0);
    check("s5 abort in_full", 32'(in_full), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("s5 abort tx_done", 32'(tx_done), 32'd0);
    end
    rst_n = 1'b1;
    write_burst(16'hA500, 224);
    check("s5 in_full", 32'(in_full), 32'd1);
    stream(16'hA500, 1'b0, 0, "s5b");
    check("s5 words", 32'(words), 32'd336);
    check("s5 tx_done count", 32'(done_cnt), 32'd1);
    check("s5 tx_done latency", 32'(done_cyc), 32'd337);

`ifdef BURST_CNT_EN
    // Burst counter: three bursts from reset, then wrap from 16'hFFFF
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      write_burst(16'h0200, 224);
      stream(16'h0200, 1'b0, 0, "s6");
      check("s6 burst_cnt", 32'(burst_cnt), 32'(b));
    end
    force dut.r_burst_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_burst_cnt;
    @(negedge clk);
    check("s6 preload", 32'(burst_cnt), 32'hFFFF);
    write_burst(16'h0200, 224);
    stream(16'h0200, 1'b0, 0, "s6w");
    check("s6 wrap", 32'(burst_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
